// File: rtl/ndp_pkg.sv
// Shared types and constant helpers for the NDP systolic-grid feed sequencer.
package ndp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ndp_skew_lane.sv
// One skew lane: enable-gated shift register whose last stage drives the array edge.
module ndp_skew_lane #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/ndp_feed_sequencer.sv
// Feed sequencer for the NDP grid: accepts K beats, skews them per lane, drains
// with zeros so the last wavefront leaves the arrays, then pulses done.
module ndp_feed_sequencer
    import ndp_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ARR_HEIGHT  = 4,
    parameter int unsigned ARR_WIDTH   = 4,
    parameter int unsigned SYS_HEIGHT  = 1,
    parameter int unsigned SYS_WIDTH   = 64,
    parameter int unsigned K_MAX       = 1024,
    parameter int unsigned DRAIN_EXTRA = 8,
    parameter int unsigned CNT_W       = clog2(K_MAX + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [CNT_W-1:0]                       k_len,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [SYS_HEIGHT*ARR_HEIGHT*WIDTH-1:0] in_a,
    input  logic [SYS_WIDTH*ARR_WIDTH*WIDTH-1:0]   in_b,
    output logic [SYS_HEIGHT*ARR_HEIGHT*WIDTH-1:0] out_a,
    output logic [SYS_WIDTH*ARR_WIDTH*WIDTH-1:0]   out_b,
    output logic                                   sys_en,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err_len
);

    localparam int unsigned A_LANES   = SYS_HEIGHT * ARR_HEIGHT;
    localparam int unsigned B_LANES   = SYS_WIDTH * ARR_WIDTH;
    localparam int unsigned DRAIN_CYC = max2(ARR_HEIGHT, ARR_WIDTH) + DRAIN_EXTRA;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    if (DRAIN_CYC > (32'd1 << CNT_W) - 32'd1) begin : g_cnt_w_check
        $error("ndp_feed_sequencer: CNT_W too narrow for the drain length");
    end

    state_e           state, state_nx;
    logic [CNT_W-1:0] beat_cnt, beat_nx;
    logic [CNT_W-1:0] drain_cnt, drain_nx;
    logic [CNT_W-1:0] k_len_q, k_len_nx;
    logic             err_nx;
    logic             advance;
    logic             feeding;
    logic             len_ok;

    assign len_ok  = (k_len != '0) && (32'(k_len) <= K_MAX);
    assign feeding = (state == FEED);

    // Next state, counters and the lane advance strobe.
    always_comb begin
        state_nx = state;
        beat_nx  = beat_cnt;
        drain_nx = drain_cnt;
        k_len_nx = k_len_q;
        err_nx   = 1'b0;
        advance  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        k_len_nx = k_len;
                        beat_nx  = '0;
                        state_nx = FEED;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            FEED: begin
                if (in_valid) begin
                    advance = 1'b1;
                    beat_nx = beat_cnt + CNT_W'(1);
                    if (beat_nx == k_len_q) begin
                        state_nx = DRAIN;
                        drain_nx = '0;
                    end
                end
            end
            DRAIN: begin
                advance = 1'b1;
                if (drain_cnt == DRAIN_LAST) state_nx = DONE;
                else                         drain_nx = drain_cnt + CNT_W'(1);
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            k_len_q   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_len   <= 1'b0;
            sys_en    <= 1'b0;
        end else begin
            state     <= state_nx;
            beat_cnt  <= beat_nx;
            drain_cnt <= drain_nx;
            k_len_q   <= k_len_nx;
            in_ready  <= (state_nx == FEED);
            busy      <= (state_nx == FEED) || (state_nx == DRAIN);
            done      <= (state_nx == DONE);
            err_len   <= err_nx;
            sys_en    <= advance;
        end
    end

    // Lane depth is the lane's position inside its own array plus one.
    for (genvar g = 0; g < A_LANES; g++) begin : g_a_lane
        ndp_skew_lane #(
            .WIDTH (WIDTH),
            .DEPTH ((g % ARR_HEIGHT) + 1)
        ) u_lane (
            .clk   (clk),
            .rst_n (reset),
            .en    (advance),
            .din   (feeding ? in_a[g*WIDTH +: WIDTH] : '0),
            .dout  (out_a[g*WIDTH +: WIDTH])
        );
    end

    for (genvar g = 0; g < B_LANES; g++) begin : g_b_lane
        ndp_skew_lane #(
            .WIDTH (WIDTH),
            .DEPTH ((g % ARR_WIDTH) + 1)
        ) u_lane (
            .clk   (clk),
            .rst_n (reset),
            .en    (advance),
            .din   (feeding ? in_b[g*WIDTH +: WIDTH] : '0),
            .dout  (out_b[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_ndp_feed_sequencer.sv
// Randomised bench for ndp_feed_sequencer against a job-level model with
// per-lane history lookup instead of shift registers.
module tb_ndp_feed_sequencer;

    localparam int unsigned W      = 16;
    localparam int unsigned AH     = 4;
    localparam int unsigned AWD    = 4;
    localparam int unsigned SH     = 1;
    localparam int unsigned SW     = 2;
    localparam int unsigned KMAX   = 1024;
    localparam int unsigned DEX    = 8;
    localparam int unsigned CW     = 11;
    localparam int unsigned A_N    = SH * AH;
    localparam int unsigned B_N    = SW * AWD;
    localparam int unsigned A_BITS = A_N * W;
    localparam int unsigned B_BITS = B_N * W;
    localparam int          DCYC   = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [CW-1:0]     k_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [A_BITS-1:0] in_a = '0;
    logic [B_BITS-1:0] in_b = '0;
    logic [A_BITS-1:0] out_a;
    logic [B_BITS-1:0] out_b;
    logic              sys_en, busy, done, err_len;

    always #5 clk = ~clk;

    ndp_feed_sequencer #(
        .WIDTH(W), .ARR_HEIGHT(AH), .ARR_WIDTH(AWD), .SYS_HEIGHT(SH),
        .SYS_WIDTH(SW), .K_MAX(KMAX), .DRAIN_EXTRA(DEX)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_a(out_a), .out_b(out_b), .sys_en(sys_en), .busy(busy),
        .done(done), .err_len(err_len)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int sys_cnt  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [A_BITS-1:0] en_log_a[$];
    logic [B_BITS-1:0] en_log_b[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 feed, 2 drain, 3 done; lanes are lookups into advance history.
    int m_mode, m_left, m_dleft;
    logic [A_BITS-1:0] hist_a[$];
    logic [B_BITS-1:0] hist_b[$];
    logic e_ready, e_busy, e_done, e_err, e_sys;
    logic [A_BITS-1:0] e_a;
    logic [B_BITS-1:0] e_b;

    task automatic model_clear();
        m_mode = 0; m_left = 0; m_dleft = 0;
        hist_a.delete(); hist_b.delete();
        e_ready = 0; e_busy = 0; e_done = 0; e_err = 0; e_sys = 0;
        e_a = '0; e_b = '0;
    endtask

    task automatic model_lanes();
        int n;
        logic [A_BITS-1:0] ta;
        logic [B_BITS-1:0] tb;
        n = hist_a.size();
        e_a = '0; e_b = '0;
        for (int g = 0; g < int'(A_N); g++) begin
            int d = (g % int'(AH)) + 1;
            if (n >= d) begin ta = hist_a[n-d]; e_a[g*W +: W] = ta[g*W +: W]; end
        end
        for (int g = 0; g < int'(B_N); g++) begin
            int d = (g % int'(AWD)) + 1;
            if (n >= d) begin tb = hist_b[n-d]; e_b[g*W +: W] = tb[g*W +: W]; end
        end
    endtask

    task automatic model_step();
        bit adv = 0;
        bit err = 0;
        logic [A_BITS-1:0] da = '0;
        logic [B_BITS-1:0] db = '0;
        case (m_mode)
            0: if (start) begin
                if (int'(k_len) >= 1 && int'(k_len) <= int'(KMAX)) begin
                    m_mode = 1; m_left = int'(k_len);
                end else err = 1;
            end
            1: if (in_valid) begin
                adv = 1; da = in_a; db = in_b; m_left--;
                if (m_left == 0) begin m_mode = 2; m_dleft = DCYC; end
            end
            2: begin adv = 1; m_dleft--; if (m_dleft == 0) m_mode = 3; end
            default: m_mode = 0;
        endcase
        if (adv) begin hist_a.push_back(da); hist_b.push_back(db); end
        e_ready = (m_mode == 1);
        e_busy  = (m_mode == 1) || (m_mode == 2);
        e_done  = (m_mode == 3);
        e_err   = err;
        e_sys   = adv;
        model_lanes();
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else        model_step();
        end
    end

    // Cycle-by-cycle comparison and event logging on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("in_ready", 128'(in_ready), 128'(e_ready));
        chk("busy",     128'(busy),     128'(e_busy));
        chk("done",     128'(done),     128'(e_done));
        chk("err_len",  128'(err_len),  128'(e_err));
        chk("sys_en",   128'(sys_en),   128'(e_sys));
        chk("out_a",    128'(out_a),    128'(e_a));
        chk("out_b",    128'(out_b),    128'(e_b));
        if (sys_en) begin sys_cnt++; en_log_a.push_back(out_a); en_log_b.push_back(out_b); end
        if (done) done_cnt++;
        if (err_len) err_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input int k);
        tick();
        start = 1'b1; k_len = CW'(k);
        tick();
        start = 1'b0;
    endtask

    // vmode 0: always valid, 1: pattern 1,0,0,1,1, else random ~60% valid.
    task automatic feed(input int k, input int vmode, input bit nominal, input bit poke);
        int beat = 0;
        int step = 0;
        bit v;
        logic [W-1:0] va, vb;
        while (beat < k) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ((step % 5) == 0) || ((step % 5) >= 3);
                default: v = ($urandom_range(0, 99) < 60);
            endcase
            in_valid = v;
            if (nominal) begin
                va = W'(16'h10 + beat); vb = W'(16'h20 + beat);
                in_a = {A_N{va}}; in_b = {B_N{vb}};
            end else begin
                in_a = {$urandom, $urandom};
                in_b = {$urandom, $urandom, $urandom, $urandom};
            end
            start = poke && ($urandom_range(0, 3) == 0);
            k_len = CW'($urandom_range(1, 50));
            if (v) beat++;
            step++;
            tick();
        end
        in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit poke, input string tag);
        int base = done_cnt;
        int i = 0;
        while (done_cnt == base && i < bound) begin
            start = poke && (i < 4); k_len = CW'(5);
            tick(); i++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 128'(done_cnt != base), 128'(1));
        tick(); tick();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, db, eb, lb, i, k;
        logic [A_BITS-1:0] la;
        logic [B_BITS-1:0] lbv;
        #1 reset = 1'b0;
        tick(); tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(0));
        chk("rst_out_a", 128'(out_a), 128'(0));
        reset = 1'b1;
        tick();

        // Nominal run, k=4.
        sb = sys_cnt; db = done_cnt; lb = en_log_a.size();
        start_job(4); feed(4, 0, 1, 0); wait_done(100, 0, "nom");
        chk("nom_sys_cnt", 128'(sys_cnt - sb), 128'(16));
        chk("nom_done_cnt", 128'(done_cnt - db), 128'(1));
        chk("nom_busy_end", 128'(busy), 128'(0));
        for (int j = 0; j < 4; j++) begin
            la = en_log_a[lb+j];
            chk("nom_a0", 128'(la[W-1:0]), 128'(16'h10 + j));
        end
        la = en_log_a[lb+3];
        chk("nom_a3_diag", 128'(la[3*W +: W]), 128'(16'h10));
        lbv = en_log_b[lb+3];
        chk("nom_b3_diag", 128'(lbv[3*W +: W]), 128'(16'h20));
        lbv = en_log_b[lb];
        chk("nom_b4_first", 128'(lbv[4*W +: W]), 128'(16'h20));

        // Stall run, k=3 with valid 1,0,0,1,1.
        sb = sys_cnt; lb = en_log_a.size();
        start_job(3); feed(3, 1, 1, 0); wait_done(100, 0, "stall");
        chk("stall_sys_cnt", 128'(sys_cnt - sb), 128'(15));
        la = en_log_a[lb+3];
        chk("stall_a3", 128'(la[3*W +: W]), 128'(16'h10));
        chk("stall_a2", 128'(la[2*W +: W]), 128'(16'h11));
        chk("stall_a1", 128'(la[1*W +: W]), 128'(16'h12));
        chk("stall_a0", 128'(la[0 +: W]),   128'(0));

        // Illegal lengths.
        sb = sys_cnt; eb = err_cnt;
        start_job(0); tick(); tick();
        chk("err_k0", 128'(err_cnt - eb), 128'(1));
        start_job(1025); tick(); tick();
        chk("err_k1025", 128'(err_cnt - eb), 128'(2));
        chk("err_busy", 128'(busy), 128'(0));
        chk("err_no_sys", 128'(sys_cnt - sb), 128'(0));

        // Start while busy.
        sb = sys_cnt; db = done_cnt;
        start_job(6); feed(6, 2, 0, 1); wait_done(200, 1, "poke");
        chk("poke_done_cnt", 128'(done_cnt - db), 128'(1));
        chk("poke_sys_cnt", 128'(sys_cnt - sb), 128'(18));
        tick(); tick();
        chk("poke_no_restart", 128'(busy), 128'(0));

        // Reset at drain_cnt=5.
        db = done_cnt;
        start_job(3); feed(3, 0, 0, 0);
        i = 0;
        while (!(m_mode == 2 && m_dleft == DCYC - 5) && i < 100) begin tick(); i++; end
        chk("rst_drain_reached", 128'(i < 100), 128'(1));
        #2 reset = 1'b0;
        #1;
        chk("async_busy", 128'(busy), 128'(0));
        chk("async_sys_en", 128'(sys_en), 128'(0));
        chk("async_out_a", 128'(out_a), 128'(0));
        chk("async_out_b", 128'(out_b), 128'(0));
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        chk("rst_no_done", 128'(done_cnt - db), 128'(0));
        sb = sys_cnt; db = done_cnt;
        start_job(2); feed(2, 0, 0, 0); wait_done(100, 0, "post_rst");
        chk("post_rst_sys", 128'(sys_cnt - sb), 128'(14));
        chk("post_rst_done", 128'(done_cnt - db), 128'(1));

        // Random jobs.
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 40);
            sb = sys_cnt;
            start_job(k); feed(k, 2, 0, r[0]); wait_done(400, r[0], "rand");
            chk("rand_sys_cnt", 128'(sys_cnt - sb), 128'(k + 12));
        end

        // K_MAX boundary.
        sb = sys_cnt; db = done_cnt;
        start_job(1024); feed(1024, 0, 0, 0); wait_done(100, 0, "kmax");
        chk("kmax_sys_cnt", 128'(sys_cnt - sb), 128'(1036));
        chk("kmax_done_cnt", 128'(done_cnt - db), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
